// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port owner: merges in-order MEM writeback with queued out-of-order long-unit results.
// Latency: the pipe write goes out in the same cycle. A long result reaches the port at least 1 cycle after it is accepted.
// Backpressure: long_ready drops when the holding FIFO is full. ID stalls on scoreboard hazards and when queued results starve.
//
// Ports:
//   clk, rst                                 clock, synchronous active-high reset
//   pipe_we/pipe_addr/pipe_data              MEM-stage writeback (always has priority)
//   issue_valid/issue_dest                   ID issues a long op; marks its destination pending
//   long_valid/long_dest/long_data/long_ready   long-unit result handshake into the holding FIFO
//   id_rd_en_l/_r, id_rd_addr_l/_r, id_we, id_dest   ID operand/destination for hazard checks
//   wr_en/wr_addr/wr_data                    register-file write port
//   stall                                    ID stall request
//   pending                                  scoreboard vector (bit 0 always 0)

// Small generic synchronous FIFO used as the long-result holding buffer.
// Latency: a pushed entry is visible at head_dat_o the cycle after the push.
// Backpressure: full_o is registered; a push while full is only taken together with a pop.
module regfile_wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign head_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read when cnt_q says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

module regfile_wb_scheduler #(
    parameter int REG_NUM      = 32,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_we,
    input  logic [ADDR_W-1:0]  pipe_addr,
    input  logic [DATA_W-1:0]  pipe_data,
    input  logic               issue_valid,
    input  logic [ADDR_W-1:0]  issue_dest,
    input  logic               long_valid,
    input  logic [ADDR_W-1:0]  long_dest,
    input  logic [DATA_W-1:0]  long_data,
    output logic               long_ready,
    input  logic               id_rd_en_l,
    input  logic [ADDR_W-1:0]  id_rd_addr_l,
    input  logic               id_rd_en_r,
    input  logic [ADDR_W-1:0]  id_rd_addr_r,
    input  logic               id_we,
    input  logic [ADDR_W-1:0]  id_dest,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               stall,
    output logic [REG_NUM-1:0] pending
);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    logic [REG_NUM-1:0] pending_q, pending_d;
    logic [REG_NUM-1:0] set_vec, clr_vec;
    logic [SC_W-1:0]    starve_q, starve_d;

    logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [ENT_W-1:0]  head_dat;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;

    logic pipe_own, starve_hit, haz_l, haz_r, haz_w;

    assign long_ready = !rst && !fifo_full;
    assign fifo_push  = long_valid && long_ready;

    // The pipeline is never delayed; the FIFO head only gets the port when the pipe leaves it free.
    assign pipe_own = pipe_we && (pipe_addr != '0);
    assign fifo_pop = !pipe_own && !fifo_empty;

    assign head_dest = head_dat[ENT_W-1:DATA_W];
    assign head_data = head_dat[DATA_W-1:0];

    regfile_wb_fifo #(
        .W     (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_long_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i ({long_dest, long_data}),
        .pop_i      (fifo_pop),
        .head_dat_o (head_dat),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    // Write-port mux. A head with destination r0 still pops but never asserts wr_en.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (!rst) begin
            if (pipe_own) begin
                wr_en   = 1'b1;
                wr_addr = pipe_addr;
                wr_data = pipe_data;
            end else if (!fifo_empty) begin
                wr_en   = (head_dest != '0);
                wr_addr = head_dest;
                wr_data = head_data;
            end
        end
    end

    // Bit 0 of the scoreboard is never set, so address-0 accesses cannot raise a hazard.
    assign haz_l      = id_rd_en_l && pending_q[id_rd_addr_l];
    assign haz_r      = id_rd_en_r && pending_q[id_rd_addr_r];
    assign haz_w      = id_we && pending_q[id_dest];
    assign starve_hit = (starve_q == SC_W'(STARVE_LIMIT));
    assign stall      = !rst && (haz_l || haz_r || haz_w || starve_hit);
    assign pending    = rst ? '0 : pending_q;

    // Scoreboard update: a new issue to a register overrides the clear from that register's older result popping.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (fifo_pop) clr_vec[head_dest] = 1'b1;
        if (issue_valid && !stall && (issue_dest != '0)) set_vec[issue_dest] = 1'b1;
        pending_d    = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;
    end

    // Starve counter: counts the cycles the head is held off by the pipeline, saturating at the limit.
    always_comb begin
        starve_d = '0;
        if (!fifo_empty && !fifo_pop) begin
            starve_d = starve_hit ? starve_q : starve_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            starve_q  <= '0;
        end else begin
            pending_q <= pending_d;
            starve_q  <= starve_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
    localparam int REG_NUM      = 32;
    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 32;
    localparam int BUF_DEPTH    = 2;
    localparam int STARVE_LIMIT = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               pipe_we;
    logic [ADDR_W-1:0]  pipe_addr;
    logic [DATA_W-1:0]  pipe_data;
    logic               issue_valid;
    logic [ADDR_W-1:0]  issue_dest;
    logic               long_valid;
    logic [ADDR_W-1:0]  long_dest;
    logic [DATA_W-1:0]  long_data;
    logic               long_ready;
    logic               id_rd_en_l;
    logic [ADDR_W-1:0]  id_rd_addr_l;
    logic               id_rd_en_r;
    logic [ADDR_W-1:0]  id_rd_addr_r;
    logic               id_we;
    logic [ADDR_W-1:0]  id_dest;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               stall;
    logic [REG_NUM-1:0] pending;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(
        .REG_NUM      (REG_NUM),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .BUF_DEPTH    (BUF_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_addr    (pipe_addr),
        .pipe_data    (pipe_data),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .long_valid   (long_valid),
        .long_dest    (long_dest),
        .long_data    (long_data),
        .long_ready   (long_ready),
        .id_rd_en_l   (id_rd_en_l),
        .id_rd_addr_l (id_rd_addr_l),
        .id_rd_en_r   (id_rd_en_r),
        .id_rd_addr_r (id_rd_addr_r),
        .id_we        (id_we),
        .id_dest      (id_dest),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .stall        (stall),
        .pending      (pending)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        logic              stall;
        logic              ready;
        logic              pop;
    } exp_t;

    ent_t               mq[$];     // queued long results, oldest first
    bit [REG_NUM-1:0]   m_pend;    // registers awaiting a long result
    int                 m_starve;  // cycles the oldest queued result has been held off

    function automatic exp_t model_expect();
        exp_t e;
        e = '{default: '0};
        if (rst) return e;
        e.ready = (mq.size() < BUF_DEPTH);
        if (pipe_we && pipe_addr != 0) begin
            e.wr_en   = 1'b1;
            e.wr_addr = pipe_addr;
            e.wr_data = pipe_data;
        end else if (mq.size() > 0) begin
            e.pop     = 1'b1;
            e.wr_en   = (mq[0].dest != 0);
            e.wr_addr = mq[0].dest;
            e.wr_data = mq[0].data;
        end
        e.stall = (id_rd_en_l && m_pend[id_rd_addr_l]) ||
                  (id_rd_en_r && m_pend[id_rd_addr_r]) ||
                  (id_we && m_pend[id_dest]) ||
                  (m_starve >= STARVE_LIMIT);
        return e;
    endfunction

    // Wait for the falling edge and compare every output with the model.
    task automatic settle();
        exp_t e;
        @(negedge clk);
        e = model_expect();
        check("m_wr_en", wr_en, e.wr_en);
        check("m_wr_addr", wr_addr, e.wr_addr);
        check("m_wr_data", wr_data, e.wr_data);
        check("m_stall", stall, e.stall);
        check("m_long_ready", long_ready, e.ready);
        check("m_pending", pending, rst ? '0 : m_pend);
    endtask

    // Cross the rising edge and advance the model with the inputs seen at that edge.
    task automatic adv();
        exp_t e;
        e = model_expect();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_pend   = '0;
            m_starve = 0;
        end else begin
            if (mq.size() > 0 && !e.pop) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
            else                         m_starve = 0;
            if (e.pop) begin
                m_pend[mq[0].dest] = 1'b0;
                mq.delete(0);
            end
            if (issue_valid && !e.stall && issue_dest != 0) m_pend[issue_dest] = 1'b1;
            if (long_valid && e.ready) mq.push_back('{dest: long_dest, data: long_data});
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic idle();
        pipe_we = 0; pipe_addr = '0; pipe_data = '0;
        issue_valid = 0; issue_dest = '0;
        long_valid = 0; long_dest = '0; long_data = '0;
        id_rd_en_l = 0; id_rd_addr_l = '0;
        id_rd_en_r = 0; id_rd_addr_r = '0;
        id_we = 0; id_dest = '0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] d);
        idle();
        issue_valid = 1; issue_dest = d;
        cyc();
        idle();
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic              pw;
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;
        logic              le;
        logic [ADDR_W-1:0] la;
        logic              re;
        logic [ADDR_W-1:0] ra;
        logic              we;
        logic [ADDR_W-1:0] wd;
        logic              x_en;
        logic [ADDR_W-1:0] x_addr;
        logic [DATA_W-1:0] x_data;
        logic              x_stall;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Rows assume pending = {r7, r12}, FIFO empty, no starvation.
        tbl[0] = '{1'b1, 5'd3,  32'h1111_1111, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd3,  32'h1111_1111, 1'b0};
        tbl[1] = '{1'b1, 5'd0,  32'h0000_0022, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         1'b0};
        tbl[2] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         1'b1};
        tbl[3] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd7,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         1'b0};
        tbl[4] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b1, 5'd12, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         1'b1};
        tbl[5] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b1, 5'd13, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         1'b0};
        tbl[6] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd12, 1'b0, 5'd0,  32'h0,         1'b1};
        tbl[7] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 5'd0,  32'h0,         1'b0};
        tbl[8] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         1'b0};
        tbl[9] = '{1'b1, 5'd31, 32'hCAFE_F00D, 1'b1, 5'd7,  1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd31, 32'hCAFE_F00D, 1'b1};

        mq.delete();
        m_pend   = '0;
        m_starve = 0;

        // Reset
        rst = 1;
        idle();
        cyc();
        cyc();
        rst = 0;

        // A: long op to r5, result two cycles later, written one cycle after acceptance
        issue(5'd5);
        cyc();
        long_valid = 1; long_dest = 5'd5; long_data = 32'hDEAD_BEEF;
        settle();
        check("A_ready", long_ready, 1);
        adv();
        idle();
        settle();
        check("A_wr_en", wr_en, 1);
        check("A_wr_addr", wr_addr, 5);
        check("A_wr_data", wr_data, 32'hDEAD_BEEF);
        check("A_pend5_before", pending[5], 1);
        adv();
        settle();
        check("A_pend5_after", pending[5], 0);
        check("A_wr_en_after", wr_en, 0);
        adv();

        // B: RAW stall on r7 until its writeback edge; r0 read never stalls
        issue(5'd7);
        id_rd_en_l = 1; id_rd_addr_l = 5'd7;
        settle();
        check("B_stall_raw", stall, 1);
        adv();
        long_valid = 1; long_dest = 5'd7; long_data = 32'h0000_0777;
        settle();
        check("B_stall_push", stall, 1);
        adv();
        long_valid = 0;
        settle();
        check("B_stall_popcyc", stall, 1);
        check("B_wr_addr", wr_addr, 7);
        adv();
        settle();
        check("B_stall_cleared", stall, 0);
        adv();
        issue(5'd7);
        id_rd_en_l = 1; id_rd_addr_l = 5'd0;
        settle();
        check("B_stall_r0", stall, 0);
        check("B_pend7", pending[7], 1);
        adv();
        idle();
        long_valid = 1; long_dest = 5'd7; long_data = 32'h0000_0007;
        cyc();
        idle();
        cyc();

        // C: pipe hogs the port; FIFO fills, starvation forces a stall, then r8/r9 drain in order
        issue(5'd8);
        issue(5'd9);
        pipe_we = 1; pipe_addr = 5'd3; pipe_data = 32'h3000_0000;
        long_valid = 1; long_dest = 5'd8; long_data = 32'h8888_8888;
        settle();
        check("C_ready_first", long_ready, 1);
        adv();
        for (int k = 0; k < 6; k++) begin
            long_valid = (k == 0); long_dest = 5'd9; long_data = 32'h9999_9999;
            pipe_data = 32'h3000_0000 + k;
            settle();
            check("C_wr_addr_pipe", wr_addr, 3);
            check("C_ready", long_ready, (k == 0));
            check("C_stall", stall, (k >= 4));
            adv();
        end
        idle();
        settle();
        check("C_r8_addr", wr_addr, 8);
        check("C_r8_data", wr_data, 32'h8888_8888);
        check("C_r8_stall", stall, 1);
        adv();
        settle();
        check("C_r9_addr", wr_addr, 9);
        check("C_r9_data", wr_data, 32'h9999_9999);
        check("C_r9_stall", stall, 0);
        adv();
        settle();
        check("C_drained", wr_en, 0);
        adv();

        // D: re-issue to r4 in the cycle its older result pops -> set wins
        issue(5'd4);
        long_valid = 1; long_dest = 5'd4; long_data = 32'h0000_4444;
        cyc();
        idle();
        issue_valid = 1; issue_dest = 5'd4;
        settle();
        check("D_pop_addr", wr_addr, 4);
        adv();
        idle();
        settle();
        check("D_pend4", pending[4], 1);
        adv();

        // E: result for r0 is accepted and popped without a write
        long_valid = 1; long_dest = 5'd0; long_data = 32'h0000_1234;
        settle();
        check("E_ready", long_ready, 1);
        adv();
        idle();
        settle();
        check("E_wr_en", wr_en, 0);
        check("E_pending", pending, 32'h0000_0010);
        adv();

        // F: reset with two queued entries and pending bits set
        issue(5'd5);
        pipe_we = 1; pipe_addr = 5'd3; pipe_data = 32'h3;
        long_valid = 1; long_dest = 5'd5; long_data = 32'h5555_0001;
        cyc();
        long_data = 32'h5555_0002;
        settle();
        check("F_ready_2nd", long_ready, 1);
        adv();
        idle();
        settle();
        check("F_full", long_ready, 0);
        rst = 1;
        settle();
        check("F_rst_wr_en", wr_en, 0);
        check("F_rst_stall", stall, 0);
        check("F_rst_ready", long_ready, 0);
        check("F_rst_pending", pending, 0);
        adv();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("F_post_wr_en", wr_en, 0);
            check("F_post_pending", pending, 0);
            check("F_post_ready", long_ready, 1);
            adv();
        end

        // Table vectors
        issue(5'd7);
        issue(5'd12);
        for (int i = 0; i < 10; i++) begin
            idle();
            pipe_we = tbl[i].pw; pipe_addr = tbl[i].pa; pipe_data = tbl[i].pd;
            id_rd_en_l = tbl[i].le; id_rd_addr_l = tbl[i].la;
            id_rd_en_r = tbl[i].re; id_rd_addr_r = tbl[i].ra;
            id_we = tbl[i].we; id_dest = tbl[i].wd;
            settle();
            check($sformatf("T%0d_wr_en", i), wr_en, tbl[i].x_en);
            check($sformatf("T%0d_wr_addr", i), wr_addr, tbl[i].x_addr);
            check($sformatf("T%0d_wr_data", i), wr_data, tbl[i].x_data);
            check($sformatf("T%0d_stall", i), stall, tbl[i].x_stall);
            adv();
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            pipe_we      = ($urandom_range(0, 99) < 70);
            pipe_addr    = ADDR_W'($urandom_range(0, REG_NUM - 1));
            if (m_pend[pipe_addr]) pipe_addr = '0;
            pipe_data    = $urandom;
            issue_valid  = ($urandom_range(0, 99) < 30);
            issue_dest   = ADDR_W'($urandom_range(0, REG_NUM - 1));
            long_valid   = ($urandom_range(0, 99) < 40);
            long_dest    = ADDR_W'($urandom_range(0, REG_NUM - 1));
            long_data    = $urandom;
            id_rd_en_l   = $urandom_range(0, 1) == 1;
            id_rd_addr_l = ADDR_W'($urandom_range(0, REG_NUM - 1));
            id_rd_en_r   = $urandom_range(0, 1) == 1;
            id_rd_addr_r = ADDR_W'($urandom_range(0, REG_NUM - 1));
            id_we        = $urandom_range(0, 1) == 1;
            id_dest      = ADDR_W'($urandom_range(0, REG_NUM - 1));
            cyc();
        end

        // Drain with a bounded number of idle cycles
        rst = 0;
        idle();
        for (int n = 0; n < 8; n++) cyc();
        settle();
        check("drain_ready", long_ready, 1);
        check("drain_wr_en", wr_en, 0);
        adv();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
